// File: rtl/cap_wr.sv
// Camera-to-VRAM frame transfer: syncs VSYNC, pops RGB444 pixels from the FIFO and
// writes one per word to sequential VRAM addresses, then drains leftovers and signals DONE.
module cap_wr #(
  parameter int HSIZE = 640,
  parameter int VSIZE = 480,
  parameter int AW    = 19
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          VSYNC,
  output logic          CAPON,
  output logic          FIFORD,
  input  logic [11:0]   FIFOOUT,
  input  logic          FIFOEMPTY,
  input  logic          FIFOFULL,
  output logic          WRREQ,
  output logic [AW-1:0] WRADDR,
  output logic [15:0]   WRDATA,
  input  logic          WRACK,
  output logic          BUSY,
  output logic          DONE,
  output logic          OVF
);

  localparam logic [AW-1:0] LAST = AW'(HSIZE * VSIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAITV, S_CAPT, S_DRAIN, S_FIN} state_t;

  state_t        state_q, state_d;
  logic          vs_meta_q, vs_s_q, vs_prev_q;
  logic          rd_q;
  logic          wrreq_q, wrreq_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          ovf_q, ovf_d;
  logic          rd_go;
  logic          vs_rise;

  assign vs_rise = vs_s_q & ~vs_prev_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      vs_meta_q <= 1'b0;
      vs_s_q    <= 1'b0;
      vs_prev_q <= 1'b0;
      rd_q      <= 1'b0;
      wrreq_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_meta_q <= VSYNC;
      vs_s_q    <= vs_meta_q;
      vs_prev_q <= vs_s_q;
      rd_q      <= rd_go;
      wrreq_q   <= wrreq_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wrreq_d = wrreq_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ovf_d   = ovf_q | (FIFOFULL & (state_q == S_CAPT));
    rd_go   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_WAITV;
          ovf_d   = 1'b0;
          addr_d  = '0;
        end
      end
      S_WAITV: begin
        if (vs_rise) state_d = S_CAPT;
      end
      S_CAPT: begin
        // One pixel at most in flight or held: a read is blocked by either.
        rd_go = ~FIFOEMPTY & ~rd_q & ~wrreq_q;
        if (rd_q) begin
          data_d  = {4'h0, FIFOOUT};
          wrreq_d = 1'b1;
        end
        if (wrreq_q && WRACK) begin
          wrreq_d = 1'b0;
          if (addr_q == LAST) state_d = S_DRAIN;
          else                addr_d  = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        rd_go = ~FIFOEMPTY & ~rd_q;
        if (vs_s_q && FIFOEMPTY && !rd_q) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign FIFORD = rd_go;
  assign CAPON  = (state_q == S_CAPT);
  assign WRREQ  = wrreq_q;
  assign WRADDR = addr_q;
  assign WRDATA = data_q;
  assign BUSY   = (state_q != S_IDLE);
  assign DONE   = (state_q == S_FIN);
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_cap_wr.sv
// Randomized bench for cap_wr: FIFO and VRAM models, a bus monitor, and a
// reference built from the frame-level rules (pushed words map to addresses 0..N-1).
module tb_cap_wr;

  localparam int HSIZE = 4;
  localparam int VSIZE = 2;
  localparam int AW    = 3;
  localparam int TOTAL = HSIZE * VSIZE;

  logic          CLK = 1'b0;
  logic          RST, START, VSYNC, FIFOFULL;
  logic          CAPON, FIFORD, WRREQ, BUSY, DONE, OVF, WRACK;
  logic [11:0]   FIFOOUT = 12'h000;
  logic          FIFOEMPTY = 1'b1;
  logic [AW-1:0] WRADDR;
  logic [15:0]   WRDATA;

  cap_wr #(.HSIZE(HSIZE), .VSIZE(VSIZE), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .VSYNC(VSYNC), .CAPON(CAPON),
    .FIFORD(FIFORD), .FIFOOUT(FIFOOUT), .FIFOEMPTY(FIFOEMPTY), .FIFOFULL(FIFOFULL),
    .WRREQ(WRREQ), .WRADDR(WRADDR), .WRDATA(WRDATA), .WRACK(WRACK),
    .BUSY(BUSY), .DONE(DONE), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  int   cyc = 0;
  logic rnd_ack = 1'b1;
  int   ack_mode = 0;

  always @(posedge CLK) begin
    cyc     <= cyc + 1;
    rnd_ack <= 1'($urandom_range(0, 1));
  end

  assign WRACK = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? (cyc % 4 == 0) : rnd_ack;

  // Non-show-ahead FIFO: a read strobed in one cycle presents data in the next.
  logic [11:0] fifo_q[$];
  int          pop_empty = 0;
  always @(posedge CLK) begin
    logic rd;
    rd = FIFORD;
    #2;
    if (rd) begin
      if (fifo_q.size() > 0) FIFOOUT = fifo_q.pop_front();
      else pop_empty++;
    end
    FIFOEMPTY = (fifo_q.size() == 0);
  end

  // Bus monitor.
  int          cap_addr[$];
  int          cap_data[$];
  int          cap_cyc[$];
  int          stab_err = 0, rd_req_err = 0, drain_reads = 0, wrreq_out = 0, done_cnt = 0;
  int          capon_fall_cyc = 0;
  logic        prev_req = 0, prev_ack = 0, prev_rst = 1, prev_capon = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  always @(negedge CLK) begin
    if (WRREQ && WRACK) begin
      cap_addr.push_back(int'(WRADDR));
      cap_data.push_back(int'(WRDATA));
      cap_cyc.push_back(cyc);
    end
    if (prev_req && !prev_ack && !prev_rst &&
        !(WRREQ && WRADDR == prev_addr && WRDATA == prev_data)) stab_err++;
    if (FIFORD && WRREQ) rd_req_err++;
    if (FIFORD && BUSY && !CAPON) drain_reads++;
    if (WRREQ && !CAPON) wrreq_out++;
    if (DONE) done_cnt++;
    if (prev_capon && !CAPON) capon_fall_cyc = cyc;
    prev_req = WRREQ; prev_ack = WRACK; prev_rst = RST; prev_capon = CAPON;
    prev_addr = WRADDR; prev_data = WRDATA;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_words(input int n, input bit seqdata, inout logic [11:0] exp_q[$]);
    logic [11:0] w;
    for (int i = 0; i < n; i++) begin
      w = seqdata ? 12'(i + 1) : 12'($urandom);
      exp_q.push_back(w);
      fifo_q.push_back(w);
    end
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
  endtask

  task automatic run_frame(input int ackm, input int nwords, input bit seqdata,
                           input bit full_pulse, input bit start_in_capt, input int idle_wait);
    logic [11:0] exp_q[$];
    int base, dr0, st0, rr0, wo0, pe0, d0, t, last;
    ack_mode = ackm;
    base = cap_addr.size();
    dr0 = drain_reads; st0 = stab_err; rr0 = rd_req_err; wo0 = wrreq_out; pe0 = pop_empty;
    d0 = done_cnt;
    pulse_start();
    @(negedge CLK);
    check_eq("busy_after_start", 32'(BUSY), 32'd1);
    check_eq("ovf_clear_on_start", 32'(OVF), 32'd0);
    push_words(nwords, seqdata, exp_q);
    repeat (idle_wait) @(posedge CLK);
    @(negedge CLK);
    check_eq("waitv_capon_low", 32'(CAPON), 32'd0);
    check_eq("waitv_busy", 32'(BUSY), 32'd1);
    check_eq("waitv_no_reads", 32'(drain_reads - dr0), 32'd0);
    @(posedge CLK); #1 VSYNC = 1'b1;
    repeat (4) @(posedge CLK);
    #1 VSYNC = 1'b0;
    t = 0;
    while (!CAPON && t < 50) begin @(negedge CLK); t++; end
    check_eq("capon_rise", 32'(CAPON), 32'd1);
    if (full_pulse) begin
      @(posedge CLK); #1 FIFOFULL = 1'b1;
      @(posedge CLK); #1 FIFOFULL = 1'b0;
    end
    if (start_in_capt) pulse_start();
    t = 0;
    while (CAPON && t < 2000) begin @(negedge CLK); t++; end
    check_eq("capon_fall", 32'(CAPON), 32'd0);
    repeat (8) @(negedge CLK);
    check_eq("no_done_before_vsync", 32'(done_cnt - d0), 32'd0);
    check_eq("busy_in_drain", 32'(BUSY), 32'd1);
    @(posedge CLK); #1 VSYNC = 1'b1;
    t = 0;
    while (done_cnt == d0 && t < 40) begin @(negedge CLK); t++; end
    check_eq("done_pulse", 32'(done_cnt - d0), 32'd1);
    @(negedge CLK);
    check_eq("done_one_cycle", 32'(DONE), 32'd0);
    check_eq("busy_after_done", 32'(BUSY), 32'd0);
    check_eq("write_count", 32'(cap_addr.size() - base), 32'(TOTAL));
    for (int i = 0; i < TOTAL && base + i < cap_addr.size(); i++) begin
      check_eq($sformatf("wr_addr[%0d]", i), 32'(cap_addr[base + i]), 32'(i));
      check_eq($sformatf("wr_data[%0d]", i), 32'(cap_data[base + i]), {20'h0, exp_q[i]});
      if (ackm == 0 && i > 0)
        check_eq($sformatf("ack_spacing[%0d]", i),
                 32'(cap_cyc[base + i] - cap_cyc[base + i - 1]), 32'd3);
    end
    if (cap_addr.size() > base) begin
      last = cap_cyc[cap_cyc.size() - 1];
      check_eq("capon_fall_after_last_ack", 32'(capon_fall_cyc), 32'(last + 1));
    end
    check_eq("drain_reads", 32'(drain_reads - dr0), 32'(nwords - TOTAL));
    check_eq("fifo_empty_at_end", 32'(FIFOEMPTY), 32'd1);
    check_eq("ovf_at_done", 32'(OVF), 32'(full_pulse));
    check_eq("hold_stable", 32'(stab_err - st0), 32'd0);
    check_eq("no_read_while_req", 32'(rd_req_err - rr0), 32'd0);
    check_eq("no_req_outside_capt", 32'(wrreq_out - wo0), 32'd0);
    check_eq("no_pop_when_empty", 32'(pop_empty - pe0), 32'd0);
    @(posedge CLK); #1 VSYNC = 1'b0;
    repeat (10) @(posedge CLK);
  endtask

  initial begin
    logic [11:0] junk_q[$];
    int base, t;
    RST = 1'b1; START = 1'b0; VSYNC = 1'b0; FIFOFULL = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("reset_outputs", {7'h0, CAPON, FIFORD, WRREQ, WRADDR, WRDATA, BUSY, DONE, OVF}, 32'h0);
    @(posedge CLK); #1 RST = 1'b0;
    repeat (4) @(posedge CLK);

    run_frame(0, TOTAL, 1'b1, 1'b0, 1'b0, 6);          // basic, data 1..8
    run_frame(1, TOTAL, 1'b0, 1'b0, 1'b0, 6);          // ack every 4th cycle
    run_frame(2, TOTAL + 3, 1'b0, 1'b0, 1'b0, 6);      // 3 leftover words drained
    run_frame(0, TOTAL + $urandom_range(0, 3), 1'b0, 1'b1, 1'b1, 6);  // overflow + START in CAPT
    run_frame(0, TOTAL, 1'b0, 1'b0, 1'b0, 40);         // long wait with no VSYNC activity

    // Abort after the third write.
    ack_mode = 1;
    base = cap_addr.size();
    pulse_start();
    push_words(TOTAL, 1'b0, junk_q);
    @(posedge CLK); #1 VSYNC = 1'b1;
    repeat (4) @(posedge CLK);
    #1 VSYNC = 1'b0;
    t = 0;
    while (cap_addr.size() - base < 3 && t < 300) begin @(negedge CLK); t++; end
    check_eq("abort_reached_3_writes", 32'(cap_addr.size() - base >= 3), 32'd1);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    check_eq("abort_outputs", {7'h0, CAPON, FIFORD, WRREQ, WRADDR, WRDATA, BUSY, DONE, OVF}, 32'h0);
    fifo_q.delete();
    repeat (3) @(posedge CLK);

    // START and RST together: reset wins.
    #1 START = 1'b1; RST = 1'b1;
    @(posedge CLK); #1 START = 1'b0; RST = 1'b0;
    @(negedge CLK);
    check_eq("start_with_rst", 32'(BUSY), 32'd0);
    repeat (3) @(posedge CLK);

    run_frame(2, TOTAL + 1, 1'b0, 1'b0, 1'b0, 6);      // restart from address 0
    for (int k = 0; k < 2; k++)
      run_frame($urandom_range(0, 2), TOTAL + $urandom_range(0, 4), 1'b0, 1'b0, 1'b0, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected test completion");
    $fatal(1, "timeout");
  end

endmodule
